// File: rtl/det_4x4_seq.sv
// Purpose: sequential 4x4 signed determinant via 2x2 minor pairs (Laplace on rows 0-1 / 2-3).
// Latency: start accepted at edge 0 -> done pulse and new results after edge 31.
// Backpressure: none; start is ignored (not queued) while busy, results held until next done.
module det_4x4_seq #(
   parameter int W   = 8,
   parameter int OW  = 8,
   parameter int SAT = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [16*W-1:0]       A,
   output logic                  busy,
   output logic                  done,
   output logic signed [OW-1:0]  det,
   output logic signed [4*W+2:0] det_full,
   output logic                  overflow_flag
);
   localparam int FW = 4*W+3;
   localparam int MW = 2*W+1;
   localparam logic signed [FW-1:0] MAXV = {{(FW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [FW-1:0] MINV = {{(FW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MINOR, ACC, OUT} state_t;

   state_t                state, state_nxt;
   logic [16*W-1:0]       a_reg;
   logic [4:0]            cnt;
   logic signed [2*W-1:0] tmp;
   logic signed [MW-1:0]  mn [0:11];
   logic signed [FW-1:0]  acc;

   logic signed [W-1:0]   el [0:15];
   logic [15:0]           idx_q;
   logic [3:0]            ix, iy;
   logic signed [2*W-1:0] prod;
   logic signed [MW-1:0]  s_sel, c_sel;
   logic signed [FW-1:0]  term;
   logic                  neg;
   logic                  ovf_c;
   logic signed [OW-1:0]  det_c;

   // Operand element indices {x0,y0,x1,y1} for minor m = x0*y0 - x1*y1 (a=0 .. p=15).
   // Minors 0-5 come from rows 0-1, minors 6-11 from rows 2-3.
   function automatic logic [15:0] minor_idx(input logic [3:0] m);
      case (m)
         4'd0:    minor_idx = {4'd0,  4'd5,  4'd1,  4'd4};
         4'd1:    minor_idx = {4'd0,  4'd6,  4'd2,  4'd4};
         4'd2:    minor_idx = {4'd0,  4'd7,  4'd3,  4'd4};
         4'd3:    minor_idx = {4'd1,  4'd6,  4'd2,  4'd5};
         4'd4:    minor_idx = {4'd1,  4'd7,  4'd3,  4'd5};
         4'd5:    minor_idx = {4'd2,  4'd7,  4'd3,  4'd6};
         4'd6:    minor_idx = {4'd8,  4'd13, 4'd9,  4'd12};
         4'd7:    minor_idx = {4'd8,  4'd14, 4'd10, 4'd12};
         4'd8:    minor_idx = {4'd8,  4'd15, 4'd11, 4'd12};
         4'd9:    minor_idx = {4'd9,  4'd14, 4'd10, 4'd13};
         4'd10:   minor_idx = {4'd9,  4'd15, 4'd11, 4'd13};
         4'd11:   minor_idx = {4'd10, 4'd15, 4'd11, 4'd14};
         default: minor_idx = 16'd0;
      endcase
   endfunction

   // Unpack the captured matrix into row-major elements.
   always_comb begin
      for (int i = 0; i < 16; i++) el[i] = $signed(a_reg[(15-i)*W +: W]);
   end

   // Even cycles multiply the first term of a minor, odd cycles the second.
   assign idx_q = minor_idx(cnt[4:1]);
   assign ix    = cnt[0] ? idx_q[7:4] : idx_q[15:12];
   assign iy    = cnt[0] ? idx_q[3:0] : idx_q[11:8];
   assign prod  = (2*W)'(el[ix]) * (2*W)'(el[iy]);

   // Accumulation pairs top minor k with bottom minor 5-k; terms 1 and 4 are subtracted.
   assign s_sel = mn[cnt[3:0]];
   assign c_sel = mn[4'd11 - cnt[3:0]];
   assign term  = FW'(s_sel) * FW'(c_sel);
   assign neg   = (cnt == 5'd1) || (cnt == 5'd4);

   // Range check and optional clamp of the exact result.
   always_comb begin
      ovf_c = (acc > MAXV) || (acc < MINV);
      det_c = acc[OW-1:0];
      if ((SAT != 0) && ovf_c)
         det_c = acc[FW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
   end

   assign busy = (state != IDLE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: 24 minor cycles, 6 accumulate cycles, one output cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = MINOR;
         MINOR:   if (cnt == 5'd23) state_nxt = ACC;
         ACC:     if (cnt == 5'd5) state_nxt = OUT;
         OUT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: capture, minor formation, accumulation and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg         <= '0;
         cnt           <= '0;
         tmp           <= '0;
         acc           <= '0;
         done          <= 1'b0;
         det           <= '0;
         det_full      <= '0;
         overflow_flag <= 1'b0;
         for (int i = 0; i < 12; i++) mn[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= A;
                  cnt   <= '0;
                  acc   <= '0;
               end
            end
            MINOR: begin
               if (!cnt[0]) tmp <= prod;
               else         mn[cnt[4:1]] <= MW'(tmp) - MW'(prod);
               cnt <= (cnt == 5'd23) ? 5'd0 : cnt + 5'd1;
            end
            ACC: begin
               acc <= neg ? acc - term : acc + term;
               cnt <= (cnt == 5'd5) ? 5'd0 : cnt + 5'd1;
            end
            OUT: begin
               det_full      <= acc;
               det           <= det_c;
               overflow_flag <= ovf_c;
               done          <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_det_4x4_seq.sv
// Purpose: self-checking bench for det_4x4_seq, wrap (SAT=0) and saturate (SAT=1) instances side by side.
// Latency: expects done exactly 32 sampling points (after edge 31) from the start edge.
// Backpressure: exercises ignored start re-pulses, back-to-back starts and mid-operation reset.
module tb_det_4x4_seq;
   localparam int W  = 8;
   localparam int OW = 8;
   localparam int FW = 4*W+3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [16*W-1:0]      A;
   logic                 busy0, done0, ovf0, busy1, done1, ovf1;
   logic signed [OW-1:0] det0, det1;
   logic signed [FW-1:0] full0, full1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [16*W-1:0] m;
      longint          full;
      longint          d0;
      longint          d1;
      longint          ovf;
   } vec_t;

   vec_t vec [0:7];

   det_4x4_seq #(.W(W), .OW(OW), .SAT(0)) u0 (
      .clk(clk), .rst(rst), .start(start), .A(A), .busy(busy0), .done(done0),
      .det(det0), .det_full(full0), .overflow_flag(ovf0));

   det_4x4_seq #(.W(W), .OW(OW), .SAT(1)) u1 (
      .clk(clk), .rst(rst), .start(start), .A(A), .busy(busy1), .done(done1),
      .det(det1), .det_full(full1), .overflow_flag(ovf1));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [16*W-1:0] pack(input int e [16]);
      logic [16*W-1:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[(15-i)*W +: W] = e[i][W-1:0];
      return r;
   endfunction

   function automatic logic [16*W-1:0] diag(input int a, input int b, input int c, input int d);
      int e [16];
      for (int i = 0; i < 16; i++) e[i] = 0;
      e[0] = a; e[5] = b; e[10] = c; e[15] = d;
      return pack(e);
   endfunction

   // Leibniz expansion over all 24 permutations of the columns.
   function automatic longint ref_det(input int e [16]);
      longint sum, t;
      int p [4];
      int inv;
      sum = 0;
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int c = 0; c < 4; c++)
               for (int d = 0; d < 4; d++) begin
                  if (a != b && a != c && a != d && b != c && b != d && c != d) begin
                     p[0] = a; p[1] = b; p[2] = c; p[3] = d;
                     inv = 0;
                     for (int i = 0; i < 4; i++)
                        for (int j = i + 1; j < 4; j++)
                           if (p[i] > p[j]) inv++;
                     t = longint'(e[a]) * longint'(e[4+b]) * longint'(e[8+c]) * longint'(e[12+d]);
                     sum = (inv % 2 == 1) ? sum - t : sum + t;
                  end
               end
      return sum;
   endfunction

   function automatic int rnd_el(input int mode);
      if (mode == 2) return int'($urandom_range(0, 6)) - 3;
      if (mode == 1 && $urandom_range(0, 2) == 0) return -128;
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   // Expected wrap/saturate outputs derived from the exact determinant.
   task automatic check_res(input string nm, input longint ef);
      logic signed [7:0] t;
      longint ov, d1;
      t  = ef[7:0];
      ov = (ef > 127 || ef < -128) ? 1 : 0;
      d1 = (ov == 1) ? ((ef > 0) ? 127 : -128) : longint'(t);
      chk({nm, "_full0"}, full0, ef);
      chk({nm, "_full1"}, full1, ef);
      chk({nm, "_det_wrap"}, det0, longint'(t));
      chk({nm, "_det_sat"}, det1, d1);
      chk({nm, "_ovf0"}, ovf0, ov);
      chk({nm, "_ovf1"}, ovf1, ov);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_busy"}, {busy0, busy1}, 0);
      chk({nm, "_done"}, {done0, done1}, 0);
      chk({nm, "_det"}, {det0, det1}, 0);
      chk({nm, "_full0"}, full0, 0);
      chk({nm, "_full1"}, full1, 0);
      chk({nm, "_ovf"}, {ovf0, ovf1}, 0);
   endtask

   // Called at a negedge: drives start for one edge and waits for done (bounded).
   task automatic do_op(input string nm, input logic [16*W-1:0] m);
      int lat;
      bit ok;
      A     = m;
      start = 1'b1;
      lat   = -1;
      ok    = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (done0 && done1) begin
            lat = c;
            break;
         end
         if (!(busy0 && busy1) || done0 || done1) ok = 1'b0;
      end
      chk({nm, "_latency"}, lat, 32);
      chk({nm, "_busy_during"}, ok, 1);
      chk({nm, "_busy_after"}, {busy0, busy1}, 0);
   endtask

   initial begin
      int e [16];
      int e2 [16];
      logic [16*W-1:0] m1, m2;
      longint ef;
      int dones, lat;

      rst   = 1'b1;
      start = 1'b0;
      A     = '0;

      for (int i = 0; i < 16; i++) e[i] = (i % 5 == 0) ? 1 : 0;
      vec[0] = '{pack(e), 1, 1, 1, 0};
      vec[1] = '{diag(2, 3, 4, 5), 120, 120, 120, 0};
      for (int i = 0; i < 16; i++) e[i] = 1;
      vec[2] = '{pack(e), 0, 0, 0, 0};
      vec[3] = '{diag(4, 4, 4, 4), 256, 0, 127, 1};
      vec[4] = '{diag(-4, 4, 4, 4), -256, 0, -128, 1};
      vec[5] = '{diag(-128, -128, -128, -128), 268435456, 0, 127, 1};
      for (int i = 0; i < 16; i++) e[i] = 0;
      e[1] = 1; e[4] = 1; e[10] = 1; e[15] = 1;
      vec[6] = '{pack(e), -1, -1, -1, 0};
      vec[7] = '{diag(3, 3, 3, 7), 189, -67, 127, 1};

      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;

      // Table vectors, issued back to back (start during the done cycle).
      for (int v = 0; v < 8; v++) begin
         do_op($sformatf("tbl%0d", v), vec[v].m);
         chk($sformatf("tbl%0d_full0", v), full0, vec[v].full);
         chk($sformatf("tbl%0d_full1", v), full1, vec[v].full);
         chk($sformatf("tbl%0d_det_wrap", v), det0, vec[v].d0);
         chk($sformatf("tbl%0d_det_sat", v), det1, vec[v].d1);
         chk($sformatf("tbl%0d_ovf", v), ovf0, vec[v].ovf);
      end

      // Randomized matrices against the permutation-expansion model.
      for (int r = 0; r < 24; r++) begin
         for (int i = 0; i < 16; i++) e[i] = rnd_el(r % 3);
         do_op($sformatf("rnd%0d", r), pack(e));
         check_res($sformatf("rnd%0d", r), ref_det(e));
      end

      // Results hold between done pulses.
      ef = ref_det(e);
      repeat (5) @(negedge clk);
      chk("hold_done", {done0, done1}, 0);
      check_res("hold", ef);

      // Start re-pulses while busy are ignored; A changes after capture are ignored.
      for (int i = 0; i < 16; i++) begin
         e[i]  = rnd_el(1);
         e2[i] = rnd_el(0);
      end
      m1 = pack(e);
      m2 = pack(e2);
      A = m1;
      start = 1'b1;
      dones = 0;
      lat = -1;
      for (int c = 1; c <= 70; c++) begin
         @(negedge clk);
         case (c)
            1:  begin start = 1'b0; A = m2; end
            5:  start = 1'b1;
            6:  start = 1'b0;
            20: start = 1'b1;
            21: start = 1'b0;
            default: ;
         endcase
         if (done0) begin
            dones++;
            if (lat < 0) lat = c;
         end
      end
      chk("repulse_dones", dones, 1);
      chk("repulse_latency", lat, 32);
      check_res("repulse", ref_det(e));

      // Reset in the middle of an operation: outputs clear at once, no done follows.
      do_op("pre_rst", diag(2, 3, 4, 5));
      check_res("pre_rst", 120);
      A = m2;
      start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
      end
      #2 rst = 1'b1;
      #1 chk_zero("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (done0 || done1) dones++;
      end
      chk("aborted_dones", dones, 0);

      // Start on the first edge after reset release.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      do_op("post_rst", m2);
      check_res("post_rst", ref_det(e2));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
